vend_dispense_ctrl: RTL and testbench

VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

---
 rtl/vend_dispense_ctrl_if.sv | 25 ++
 rtl/vend_dispense_ctrl.sv | 157 +++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_ctrl_if.sv
// Handshake bundle between the upstream vending FSM, the drop sensor and the dispense controller.
// master drives events and sensor inputs; slave is the controller side.
interface vend_dispense_ctrl_if;
    logic       vend_req;
    logic [1:0] change_code;
    logic       product_sensed;
    logic       fault_clr;
    logic       motor_en;
    logic       hopper_kick;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic       fault;
    logic [7:0] vend_count;

    modport master (
        output vend_req, change_code, product_sensed, fault_clr,
        input  motor_en, hopper_kick, busy, fifo_full, overflow, fault, vend_count
    );

    modport slave (
        input  vend_req, change_code, product_sensed, fault_clr,
        output motor_en, hopper_kick, busy, fifo_full, overflow, fault, vend_count
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense controller: queues vend/change events in a 4-deep FIFO and sequences the motor,
// drop-sensor wait and coin hopper for each entry.
module vend_dispense_ctrl #(
    parameter int unsigned MOTOR_CYCLES  = 8,
    parameter int unsigned SENSE_TIMEOUT = 64,
    parameter int unsigned HOP_GAP       = 2
) (
    input logic                  clk,
    input logic                  rst,
    vend_dispense_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StMotor, StSense, StHopper, StGap, StFault} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  coins_q, coins_d;
    logic [7:0]  vend_count_q, vend_count_d;
    logic        motor_en_q, motor_en_d;
    logic        hopper_kick_q, hopper_kick_d;
    logic        overflow_q, overflow_d;

    logic [2:0]  mem_q [4];
    logic [2:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  fcnt_q, fcnt_d;

    logic        push, pop, push_ok, full;
    logic [2:0]  head;

    // FIFO: pop only when non-empty, so a push into an empty FIFO never bypasses.
    always_comb begin
        push     = bus.vend_req | (bus.change_code != 2'b00);
        full     = (fcnt_q == 3'd4);
        pop      = (state_q == StIdle) && (fcnt_q != 3'd0);
        push_ok  = push && (!full || pop);
        head     = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {bus.vend_req, bus.change_code};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        unique case ({push_ok, pop})
            2'b10:   fcnt_d = fcnt_q + 3'd1;
            2'b01:   fcnt_d = fcnt_q - 3'd1;
            default: fcnt_d = fcnt_q;
        endcase
        overflow_d = overflow_q | (push && !push_ok);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        coins_d      = coins_q;
        vend_count_d = vend_count_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    coins_d = head[1:0];
                    cnt_d   = '0;
                    if (head[2]) begin
                        state_d = StMotor;
                    end else if (head[1:0] != 2'b00) begin
                        state_d = StHopper;
                    end
                end
            end
            StMotor: begin
                if (cnt_q == 16'(MOTOR_CYCLES - 1)) begin
                    state_d = StSense;
                    cnt_d   = 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSense: begin
                if (bus.product_sensed) begin
                    if (vend_count_q != 8'hFF) begin
                        vend_count_d = vend_count_q + 8'd1;
                    end
                    state_d = (coins_q != 2'b00) ? StHopper : StIdle;
                end else if (cnt_q == 16'(SENSE_TIMEOUT)) begin
                    state_d = StFault;
                    coins_d = 2'b00;  // change of a faulted vend is forfeited
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StHopper: begin
                coins_d = coins_q - 2'd1;
                cnt_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (cnt_q == 16'(HOP_GAP - 1)) begin
                    state_d = (coins_q != 2'b00) ? StHopper : StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StFault: begin
                if (bus.fault_clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        motor_en_d    = (state_d == StMotor);
        hopper_kick_d = (state_d == StHopper);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            coins_q       <= '0;
            vend_count_q  <= '0;
            motor_en_q    <= 1'b0;
            hopper_kick_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fcnt_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            coins_q       <= coins_d;
            vend_count_q  <= vend_count_d;
            motor_en_q    <= motor_en_d;
            hopper_kick_q <= hopper_kick_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fcnt_q        <= fcnt_d;
            mem_q         <= mem_d;
        end
    end

    assign bus.motor_en    = motor_en_q;
    assign bus.hopper_kick = hopper_kick_q;
    assign bus.busy        = (state_q != StIdle) || (fcnt_q != 3'd0);
    assign bus.fifo_full   = full;
    assign bus.overflow    = overflow_q;
    assign bus.fault       = (state_q == StFault);
    assign bus.vend_count  = vend_count_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: per-cycle vector table plus hand sequences for
// timeout, overflow, mid-operation reset and count saturation.
module tb_vend_dispense_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_dispense_ctrl_if bus ();

    vend_dispense_ctrl #(
        .MOTOR_CYCLES (8),
        .SENSE_TIMEOUT(64),
        .HOP_GAP      (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        vend;
        logic [1:0]  code;
        logic        sense;
        logic        clr;
        logic [13:0] exp;  // {motor, kick, busy, full, ovf, fault, count[7:0]}
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [13:0] outs();
        return {bus.motor_en, bus.hopper_kick, bus.busy, bus.fifo_full, bus.overflow,
                bus.fault, bus.vend_count};
    endfunction

    task automatic add(input logic v, input logic [1:0] c, input logic s, input logic cl,
                       input logic m, input logic k, input logic b, input logic [7:0] cnt);
        vec_t r;
        r.vend  = v;
        r.code  = c;
        r.sense = s;
        r.clr   = cl;
        r.exp   = {m, k, b, 1'b0, 1'b0, 1'b0, cnt};
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] c, input logic s, input logic cl);
        bus.vend_req       = v;
        bus.change_code    = c;
        bus.product_sensed = s;
        bus.fault_clr      = cl;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    int motor_seen;
    int kick_seen;
    int busy_seen;
    int waited;

    initial begin
        rst = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 1'b0);

        // Change-only entry 11: kicks two edges after the event, 2 low cycles between kicks.
        add(0, 2'b11, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 1, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0);
        // Vend with change 10: 8 motor cycles (sensor and fault_clr ignored there), sensed at
        // the 3rd SENSE cycle, then two kicks 3 cycles apart.
        add(1, 2'b10, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        add(0, 2'b00, 0, 1, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        add(0, 2'b00, 1, 0, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 1, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 0, 0, 0, 0, 1, 0);
        add(0, 2'b00, 1, 0, 0, 1, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 1, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 0, 1);

        // Reset state while rst is held.
        tick();
        tick();
        chk("reset_outputs", 32'(outs()), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].vend, vecs[i].code, vecs[i].sense, vecs[i].clr);
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        set_in(1'b0, 2'b00, 1'b0, 1'b0);

        // Sensor timeout: fault after 8 motor + 64 sense cycles; change is discarded.
        apply_reset();
        set_in(1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0);
        motor_seen = 0;
        kick_seen  = 0;
        for (int k = 1; k <= 72; k++) begin
            tick();
            if (bus.motor_en) motor_seen++;
            if (bus.hopper_kick) kick_seen++;
        end
        chk("timeout_motor_cycles", 32'(motor_seen), 32'd8);
        chk("timeout_no_fault_yet", 32'(bus.fault), 32'd0);
        tick();
        chk("timeout_fault", 32'(bus.fault), 32'd1);
        chk("timeout_motor_off", 32'(bus.motor_en), 32'd0);
        tick();
        chk("fault_held", 32'(bus.fault), 32'd1);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        chk("fault_clr_idle", 32'({bus.fault, bus.busy}), 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.hopper_kick) kick_seen++;
        end
        chk("timeout_no_kick", 32'(kick_seen), 32'd0);
        chk("timeout_count", 32'(bus.vend_count), 32'd0);

        // Overflow: 6 back-to-back vends, 1 popped, 4 queued, 6th dropped.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            bus.vend_req = 1'b1;
            tick();
            if (i == 4) chk("ovf_full_at5", 32'({bus.fifo_full, bus.overflow}), 32'b10);
            if (i == 5) chk("ovf_full_at6", 32'({bus.fifo_full, bus.overflow}), 32'b11);
        end
        bus.vend_req = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ovf_reset_clear", 32'({bus.overflow, bus.fifo_full, bus.busy}), 32'd0);
        tick();
        rst = 1'b0;

        // Reset in the 4th motor cycle aborts the vend; events during reset are not captured.
        apply_reset();
        bus.vend_req = 1'b1;
        tick();
        bus.vend_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("motor_4th_cycle", 32'(bus.motor_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("motor_reset_async", 32'(outs()), 32'd0);
        bus.vend_req = 1'b1;
        tick();
        tick();
        bus.vend_req = 1'b0;
        rst = 1'b0;
        motor_seen = 0;
        kick_seen  = 0;
        busy_seen  = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.motor_en) motor_seen++;
            if (bus.hopper_kick) kick_seen++;
            if (bus.busy) busy_seen++;
        end
        chk("post_reset_quiet", 32'(motor_seen + kick_seen + busy_seen), 32'd0);
        chk("post_reset_count", 32'(bus.vend_count), 32'd0);

        // Saturation: 256 successful vends with the sensor held high.
        apply_reset();
        bus.product_sensed = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            bus.vend_req = 1'b1;
            tick();
            bus.vend_req = 1'b0;
            waited = 0;
            while (bus.busy && waited < 40) begin
                tick();
                waited++;
            end
            if (waited >= 40) begin
                chk("sat_busy_timeout", 32'(bus.busy), 32'd0);
                break;
            end
            if (n == 1) chk("sat_count_1", 32'(bus.vend_count), 32'd1);
            if (n == 255) chk("sat_count_255", 32'(bus.vend_count), 32'd255);
            if (n == 256) chk("sat_count_256", 32'(bus.vend_count), 32'd255);
        end
        bus.product_sensed = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
